// File: rtl/sched_pkg.sv
// Shared types for processor_scheduler: FSM state encoding, error cause codes
// and small helpers for deriving the processor ID width and validating targets.
package sched_pkg;

    typedef enum logic [1:0] {
        ST_BOOT    = 2'd0,
        ST_RUN     = 2'd1,
        ST_HANDOFF = 2'd2,
        ST_ERROR   = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        CAUSE_NONE       = 2'd0,
        CAUSE_FATAL      = 2'd1,
        CAUSE_BAD_TARGET = 2'd2,
        CAUSE_WATCHDOG   = 2'd3
    } cause_t;

    function automatic int id_width(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

    function automatic logic target_valid(input int tgt, input int n);
        return tgt < n;
    endfunction

endpackage

// File: rtl/sched_bus_mux.sv
// Selects the owner's memory/GPU/interrupt slices onto the shared bus; the
// whole bus reads as zero whenever gate is low.
module sched_bus_mux
    import sched_pkg::*;
#(
    parameter int NUM_PROC = 4,
    parameter int ADDR_W   = 16,
    parameter int DATA_W   = 16,
    localparam int ID_W    = id_width(NUM_PROC)
) (
    input  logic [ID_W-1:0]            owner,
    input  logic                       gate,
    input  logic [NUM_PROC-1:0]        p_mem_enable,
    input  logic [NUM_PROC-1:0]        p_mem_write,
    input  logic [NUM_PROC*ADDR_W-1:0] p_mem_addr,
    input  logic [NUM_PROC*DATA_W-1:0] p_mem_data_w,
    input  logic [NUM_PROC-1:0]        p_gpu_draw,
    input  logic [NUM_PROC-1:0]        p_gpu_request,
    input  logic [NUM_PROC-1:0]        p_iack,
    input  logic [NUM_PROC-1:0]        p_iend,
    output logic                       mem_enable,
    output logic                       mem_write,
    output logic [ADDR_W-1:0]          mem_addr,
    output logic [DATA_W-1:0]          mem_data_w,
    output logic                       gpu_draw,
    output logic                       gpu_request,
    output logic                       iack,
    output logic                       iend
);

    always_comb begin
        mem_enable  = 1'b0;
        mem_write   = 1'b0;
        mem_addr    = '0;
        mem_data_w  = '0;
        gpu_draw    = 1'b0;
        gpu_request = 1'b0;
        iack        = 1'b0;
        iend        = 1'b0;
        for (int i = 0; i < NUM_PROC; i++) begin
            if (gate && owner == ID_W'(i)) begin
                mem_enable  = p_mem_enable[i];
                mem_write   = p_mem_write[i];
                mem_addr    = p_mem_addr[i*ADDR_W +: ADDR_W];
                mem_data_w  = p_mem_data_w[i*DATA_W +: DATA_W];
                gpu_draw    = p_gpu_draw[i];
                gpu_request = p_gpu_request[i];
                iack        = p_iack[i];
                iend        = p_iend[i];
            end
        end
    end

endmodule

// File: rtl/processor_scheduler.sv
// Time-multiplexes NUM_PROC processors onto one shared bus with an idle
// handoff cycle between owners and a sticky fatal-error state.
// Optional watchdog: define SCHED_WATCHDOG_EN.
module processor_scheduler
    import sched_pkg::*;
#(
    parameter int NUM_PROC   = 4,
    parameter int ADDR_W     = 16,
    parameter int DATA_W     = 16,
    parameter int BOOT_ID    = 0,
    parameter int WDT_CYCLES = 50000000,
    localparam int ID_W      = id_width(NUM_PROC)
) (
    input  logic                       CLK,
    input  logic                       IN_PB_RESET,
    input  logic [NUM_PROC-1:0]        p_switch_req,
    input  logic [NUM_PROC*ID_W-1:0]   p_switch_target,
    input  logic [NUM_PROC-1:0]        p_fatal,
    input  logic [NUM_PROC-1:0]        p_mem_enable,
    input  logic [NUM_PROC-1:0]        p_mem_write,
    input  logic [NUM_PROC*ADDR_W-1:0] p_mem_addr,
    input  logic [NUM_PROC*DATA_W-1:0] p_mem_data_w,
    input  logic [NUM_PROC-1:0]        p_gpu_draw,
    input  logic [NUM_PROC-1:0]        p_gpu_request,
    input  logic [NUM_PROC-1:0]        p_iack,
    input  logic [NUM_PROC-1:0]        p_iend,
    output logic [NUM_PROC-1:0]        proc_enable,
    output logic [ID_W-1:0]            active_id,
    output logic                       mem_enable,
    output logic                       mem_write,
    output logic [ADDR_W-1:0]          mem_addr,
    output logic [DATA_W-1:0]          mem_data_w,
    output logic                       gpu_draw,
    output logic                       gpu_request,
    output logic                       iack,
    output logic                       iend,
    output logic                       error,
    output logic [ID_W-1:0]            error_id,
    output logic [1:0]                 error_cause
);

    state_t          state, state_next;
    cause_t          cause, cause_next;
    logic [ID_W-1:0] owner, owner_next;
    logic [ID_W-1:0] pending, pending_next;
    logic [ID_W-1:0] err_id, err_id_next;
    logic            bus_gate;
    logic            wdt_expire;

    // Only the current owner's control inputs are ever looked at.
    logic            own_req, own_fatal;
    logic [ID_W-1:0] own_tgt;

    always_comb begin
        own_req   = 1'b0;
        own_fatal = 1'b0;
        own_tgt   = '0;
        for (int i = 0; i < NUM_PROC; i++) begin
            if (owner == ID_W'(i)) begin
                own_req   = p_switch_req[i];
                own_fatal = p_fatal[i];
                own_tgt   = p_switch_target[i*ID_W +: ID_W];
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (!IN_PB_RESET) begin
            state   <= ST_BOOT;
            owner   <= ID_W'(BOOT_ID);
            pending <= ID_W'(BOOT_ID);
            err_id  <= '0;
            cause   <= CAUSE_NONE;
        end else begin
            state   <= state_next;
            owner   <= owner_next;
            pending <= pending_next;
            err_id  <= err_id_next;
            cause   <= cause_next;
        end
    end

    always_comb begin
        state_next   = state;
        owner_next   = owner;
        pending_next = pending;
        err_id_next  = err_id;
        cause_next   = cause;
        case (state)
            ST_BOOT: state_next = ST_RUN;
            ST_RUN: begin
                if (own_fatal) begin
                    state_next  = ST_ERROR;
                    cause_next  = CAUSE_FATAL;
                    err_id_next = owner;
                end else if (own_req) begin
                    if (!target_valid(int'(own_tgt), NUM_PROC)) begin
                        state_next  = ST_ERROR;
                        cause_next  = CAUSE_BAD_TARGET;
                        err_id_next = owner;
                    end else begin
                        state_next   = ST_HANDOFF;
                        pending_next = own_tgt;
                    end
                end else if (wdt_expire) begin
                    state_next  = ST_ERROR;
                    cause_next  = CAUSE_WATCHDOG;
                    err_id_next = owner;
                end
            end
            ST_HANDOFF: begin
                state_next = ST_RUN;
                owner_next = pending;
            end
            default: state_next = ST_ERROR;
        endcase
    end

    always_comb begin
        proc_enable = '0;
        bus_gate    = 1'b0;
        error       = 1'b0;
        case (state)
            ST_RUN: begin
                bus_gate = 1'b1;
                for (int i = 0; i < NUM_PROC; i++)
                    proc_enable[i] = (owner == ID_W'(i));
            end
            ST_ERROR: error = 1'b1;
            default: ;
        endcase
    end

    assign active_id   = owner;
    assign error_id    = err_id;
    assign error_cause = cause;

`ifdef SCHED_WATCHDOG_EN
    localparam int WDT_W = $clog2(WDT_CYCLES + 1);
    logic [WDT_W-1:0] wdt_cnt;

    assign wdt_expire = (state == ST_RUN) && !mem_enable
                        && (wdt_cnt == WDT_W'(WDT_CYCLES - 1));

    // Counts idle RUN cycles; frozen outside RUN, cleared on entry to RUN.
    always_ff @(posedge CLK) begin
        if (!IN_PB_RESET)
            wdt_cnt <= '0;
        else if (state == ST_RUN)
            wdt_cnt <= mem_enable ? '0 : wdt_cnt + WDT_W'(1);
        else if (state_next == ST_RUN)
            wdt_cnt <= '0;
    end
`else
    localparam int UNUSED_WDT_CYCLES = WDT_CYCLES;
    assign wdt_expire = 1'b0;
`endif

    sched_bus_mux #(
        .NUM_PROC(NUM_PROC),
        .ADDR_W  (ADDR_W),
        .DATA_W  (DATA_W)
    ) u_bus_mux (
        .owner        (owner),
        .gate         (bus_gate),
        .p_mem_enable (p_mem_enable),
        .p_mem_write  (p_mem_write),
        .p_mem_addr   (p_mem_addr),
        .p_mem_data_w (p_mem_data_w),
        .p_gpu_draw   (p_gpu_draw),
        .p_gpu_request(p_gpu_request),
        .p_iack       (p_iack),
        .p_iend       (p_iend),
        .mem_enable   (mem_enable),
        .mem_write    (mem_write),
        .mem_addr     (mem_addr),
        .mem_data_w   (mem_data_w),
        .gpu_draw     (gpu_draw),
        .gpu_request  (gpu_request),
        .iack         (iack),
        .iend         (iend)
    );

endmodule

// File: tb/tb_processor_scheduler.sv
// Random-stimulus scoreboard bench: a 4-processor and a 3-processor scheduler
// share stimulus and are each checked every cycle against a behavioural model.
module tb_processor_scheduler;

    logic CLK = 1'b0;
    always #5 CLK = ~CLK;

    logic        rst_n;
    logic [3:0]  sw_req, fatal, men, mwr, gd, gr, ia, ie;
    logic [7:0]  sw_tgt;
    logic [63:0] maddr, mdata;

    typedef struct {
        logic [3:0]  pe;
        logic [1:0]  aid;
        logic        me, mw;
        logic [15:0] ad, dw;
        logic        gd, gr, ia, ie, er;
        logic [1:0]  eid, ec;
    } obs_t;

    // DUT with 4 processors
    logic [3:0]  pe4;
    logic [1:0]  aid4, eid4, ec4;
    logic        me4, mw4, gd4, gr4, ia4, ie4, er4;
    logic [15:0] ad4, dw4;

    processor_scheduler #(.NUM_PROC(4)) dut4 (
        .CLK(CLK), .IN_PB_RESET(rst_n),
        .p_switch_req(sw_req), .p_switch_target(sw_tgt), .p_fatal(fatal),
        .p_mem_enable(men), .p_mem_write(mwr), .p_mem_addr(maddr), .p_mem_data_w(mdata),
        .p_gpu_draw(gd), .p_gpu_request(gr), .p_iack(ia), .p_iend(ie),
        .proc_enable(pe4), .active_id(aid4),
        .mem_enable(me4), .mem_write(mw4), .mem_addr(ad4), .mem_data_w(dw4),
        .gpu_draw(gd4), .gpu_request(gr4), .iack(ia4), .iend(ie4),
        .error(er4), .error_id(eid4), .error_cause(ec4)
    );

    // DUT with 3 processors: target 3 is an illegal request
    logic [2:0]  pe3;
    logic [1:0]  aid3, eid3, ec3;
    logic        me3, mw3, gd3, gr3, ia3, ie3, er3;
    logic [15:0] ad3, dw3;

    processor_scheduler #(.NUM_PROC(3)) dut3 (
        .CLK(CLK), .IN_PB_RESET(rst_n),
        .p_switch_req(sw_req[2:0]), .p_switch_target(sw_tgt[5:0]), .p_fatal(fatal[2:0]),
        .p_mem_enable(men[2:0]), .p_mem_write(mwr[2:0]), .p_mem_addr(maddr[47:0]),
        .p_mem_data_w(mdata[47:0]),
        .p_gpu_draw(gd[2:0]), .p_gpu_request(gr[2:0]), .p_iack(ia[2:0]), .p_iend(ie[2:0]),
        .proc_enable(pe3), .active_id(aid3),
        .mem_enable(me3), .mem_write(mw3), .mem_addr(ad3), .mem_data_w(dw3),
        .gpu_draw(gd3), .gpu_request(gr3), .iack(ia3), .iend(ie3),
        .error(er3), .error_id(eid3), .error_cause(ec3)
    );

    // Reference model: which processor owns the bus, and what phase it is in.
    localparam int M_BOOT = 0, M_RUN = 1, M_HAND = 2, M_ERR = 3;
    typedef struct {
        int mode;
        int owner;
        int pend;
        int eid;
        int ec;
    } mdl_t;

    mdl_t m [2];
    int   np [2] = '{4, 3};
    obs_t q0 [$];
    obs_t q1 [$];
    int   checks = 0;
    int   errors = 0;

    task automatic step(input int k);
        int o, t;
        if (!rst_n) begin
            m[k].mode = M_BOOT; m[k].owner = 0; m[k].eid = 0; m[k].ec = 0;
            return;
        end
        o = m[k].owner;
        case (m[k].mode)
            M_BOOT: m[k].mode = M_RUN;
            M_RUN: begin
                t = int'((sw_tgt >> (2 * o)) & 8'h3);
                if (fatal[o]) begin
                    m[k].mode = M_ERR; m[k].ec = 1; m[k].eid = o;
                end else if (sw_req[o] && t >= np[k]) begin
                    m[k].mode = M_ERR; m[k].ec = 2; m[k].eid = o;
                end else if (sw_req[o]) begin
                    m[k].mode = M_HAND; m[k].pend = t;
                end
            end
            M_HAND: begin
                m[k].owner = m[k].pend; m[k].mode = M_RUN;
            end
            default: ;
        endcase
    endtask

    function automatic obs_t expect_out(input int k);
        obs_t e;
        int   o;
        o = m[k].owner;
        e = '{pe: 4'b0, aid: 2'(o), me: 1'b0, mw: 1'b0, ad: 16'h0, dw: 16'h0,
              gd: 1'b0, gr: 1'b0, ia: 1'b0, ie: 1'b0, er: (m[k].mode == M_ERR),
              eid: 2'(m[k].eid), ec: 2'(m[k].ec)};
        if (m[k].mode == M_RUN) begin
            e.pe = 4'(1 << o);
            e.me = men[o]; e.mw = mwr[o];
            e.ad = 16'(maddr >> (16 * o));
            e.dw = 16'(mdata >> (16 * o));
            e.gd = gd[o]; e.gr = gr[o]; e.ia = ia[o]; e.ie = ie[o];
        end
        return e;
    endfunction

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cmp_obs(input string tag, input obs_t a, input obs_t e);
        chk({tag, ".proc_enable"}, 16'(a.pe), 16'(e.pe));
        chk({tag, ".active_id"},   16'(a.aid), 16'(e.aid));
        chk({tag, ".mem_enable"},  16'(a.me), 16'(e.me));
        chk({tag, ".mem_write"},   16'(a.mw), 16'(e.mw));
        chk({tag, ".mem_addr"},    a.ad, e.ad);
        chk({tag, ".mem_data_w"},  a.dw, e.dw);
        chk({tag, ".gpu_strobes"}, 16'({a.gd, a.gr, a.ia, a.ie}), 16'({e.gd, e.gr, e.ia, e.ie}));
        chk({tag, ".error"},       16'(a.er), 16'(e.er));
        chk({tag, ".error_id"},    16'(a.eid), 16'(e.eid));
        chk({tag, ".error_cause"}, 16'(a.ec), 16'(e.ec));
    endtask

    // Monitor: compares whatever the DUTs present against queued expectations.
    always @(negedge CLK) begin
        obs_t a, e;
        if (q0.size() > 0) begin
            e = q0.pop_front();
            a = '{pe: pe4, aid: aid4, me: me4, mw: mw4, ad: ad4, dw: dw4, gd: gd4,
                  gr: gr4, ia: ia4, ie: ie4, er: er4, eid: eid4, ec: ec4};
            cmp_obs("np4", a, e);
        end
        if (q1.size() > 0) begin
            e = q1.pop_front();
            a = '{pe: {1'b0, pe3}, aid: aid3, me: me3, mw: mw3, ad: ad3, dw: dw3, gd: gd3,
                  gr: gr3, ia: ia3, ie: ie3, er: er3, eid: eid3, ec: ec3};
            cmp_obs("np3", a, e);
        end
    end

    initial begin
        int err_cycles = 0;
        rst_n = 1'b0;
        sw_req = '0; fatal = '0; sw_tgt = '0; men = '1; mwr = '0;
        maddr = '0; mdata = '0; gd = '0; gr = '0; ia = '0; ie = '0;
        m[0] = '{M_BOOT, 0, 0, 0, 0};
        m[1] = '{M_BOOT, 0, 0, 0, 0};

        for (int c = 0; c < 4000; c++) begin
            @(posedge CLK);
            step(0);
            step(1);
            #1;
            if (m[0].mode == M_ERR || m[1].mode == M_ERR) err_cycles++;
            if (c < 3) rst_n = 1'b0;
            else if (err_cycles >= 5) begin
                rst_n = 1'b0;
                err_cycles = 0;
            end else rst_n = ($urandom % 400 != 0);
            for (int i = 0; i < 4; i++) begin
                sw_req[i] = ($urandom % 6 == 0);
                fatal[i]  = ($urandom % 120 == 0);
            end
            sw_tgt = 8'($urandom);
            men = 4'($urandom); mwr = 4'($urandom);
            maddr = {$urandom, $urandom}; mdata = {$urandom, $urandom};
            gd = 4'($urandom); gr = 4'($urandom); ia = 4'($urandom); ie = 4'($urandom);
            q0.push_back(expect_out(0));
            q1.push_back(expect_out(1));
        end
        @(negedge CLK);
        #1;
        checks++;
        if (q0.size() != 0 || q1.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d/%0d pending expected 0", q0.size(), q1.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/processor_scheduler.md
Name: processor_scheduler

Overview:
- Generalised successor to the two-processor title/game switch in the top level.
- Time-multiplexes NUM_PROC application processors onto the shared memory, GPU and interrupt-acknowledge signals. Exactly one processor is enabled at a time.
- Processors hand off by requesting a target processor ID. A guaranteed idle handoff cycle separates owners on the bus.
- A sticky fatal-error state drives the LED/buzzer and reports the cause.

Parameters:
- NUM_PROC, 4, number of processors, at least 2; ID_W = $clog2(NUM_PROC) is a derived localparam.
- ADDR_W, 16, memory address width.
- DATA_W, 16, memory write-data width.
- BOOT_ID, 0, processor enabled after reset; must be below NUM_PROC.
- WDT_CYCLES, 50000000, watchdog timeout in clocks; used only with SCHED_WATCHDOG_EN.

Ports:
- CLK  in  1  system clock.
- IN_PB_RESET  in  1  synchronous, active-low reset.
- p_switch_req  in  NUM_PROC  per-processor switch request.
- p_switch_target  in  NUM_PROC*ID_W  per-processor target ID; slice i belongs to processor i.
- p_fatal  in  NUM_PROC  per-processor fatal error.
- p_mem_enable, p_mem_write  in  NUM_PROC each  per-processor memory strobes.
- p_mem_addr  in  NUM_PROC*ADDR_W  per-processor address.
- p_mem_data_w  in  NUM_PROC*DATA_W  per-processor write data.
- p_gpu_draw, p_gpu_request, p_iack, p_iend  in  NUM_PROC each  per-processor GPU and interrupt strobes.
- proc_enable  out  NUM_PROC  one-hot enable, or all zero.
- active_id  out  ID_W  current owner.
- mem_enable, mem_write  out  1  muxed memory strobes.
- mem_addr  out  ADDR_W  muxed address.
- mem_data_w  out  DATA_W  muxed write data.
- gpu_draw, gpu_request, iack, iend  out  1  muxed strobes.
- error  out  1  sticky fatal flag.
- error_id  out  ID_W  processor that caused the error.
- error_cause  out  2  cause code: 0 none, 1 fatal, 2 bad target, 3 watchdog.

Behaviour:
- States: BOOT, RUN, HANDOFF, ERROR. The state, owner ID, error_id and error_cause are registered.
- All outputs are decoded from registered state only, with no input-to-output combinational path except the data mux selected by the registered owner.
- Reset (IN_PB_RESET=0 at a clock edge, in any state):
  - state<=BOOT, owner<=BOOT_ID, error_cause<=0, error_id<=0.
  - proc_enable=0, all muxed outputs=0, error=0.
- BOOT -> RUN unconditionally after 1 cycle.
- RUN:
  - proc_enable = one-hot at the owner bit; all muxed outputs follow the owner's slices combinationally.
  - Only the owner's p_switch_req and p_fatal are sampled. Other processors' inputs are ignored entirely.
  - Priority at a clock edge: fatal > bad target > switch.
  - p_fatal[owner]=1: next state ERROR, cause 1, error_id<=owner.
  - p_switch_req[owner]=1 with target >= NUM_PROC: next state ERROR, cause 2, error_id<=owner. This is only reachable when NUM_PROC is not a power of two.
  - p_switch_req[owner]=1 with a valid target: latch the target into pending, next state HANDOFF.
  - A target equal to owner is legal; it restarts the same processor through HANDOFF.
- HANDOFF, exactly 1 cycle:
  - proc_enable=0 and all muxed strobes/data=0.
  - active_id shows the old owner.
  - Next state RUN with owner<=pending.
  - Switch latency: request at edge t; HANDOFF during cycle t+1; new owner enabled from edge t+2.
- ERROR (sticky until reset):
  - proc_enable=0, muxed outputs=0, error=1.
  - error_id and error_cause hold their values.
  - New requests and faults are ignored.

Optional Feature:
- Macro: SCHED_WATCHDOG_EN.
- Defined:
  - A counter of width $clog2(WDT_CYCLES+1) clears on every RUN cycle with mem_enable=1, on entry to RUN, and on reset.
  - It increments on other RUN cycles.
  - Reaching WDT_CYCLES-1 without a clear forces ERROR, cause 3, error_id=owner. Same-edge fatal or switch takes priority.
  - The counter is frozen in HANDOFF and ERROR.
- Undefined: no counter is present, and cause 3 never occurs.

Decomposition:
- Package sched_pkg: state encoding (BOOT, RUN, HANDOFF, ERROR), error_cause constants, ID-width helper function.
- One natural sub-module, sched_bus_mux: parametrised by NUM_PROC, ADDR_W, DATA_W. It takes owner and gate, and emits the muxed bus, zeroed when gate=0.

Test Plan:
- Reset: hold IN_PB_RESET low 3 cycles, release -> cycle 1 proc_enable=0; cycle 2 proc_enable=4'b0001, active_id=0, error=0.
- Switch: in RUN with owner 0, pulse p_switch_req[0] with target 2 -> next cycle proc_enable=0 and mem_enable=0 despite p_mem_enable=4'b1111; following cycle proc_enable=4'b0100 and mem_addr equals processor 2's slice.
- Non-owner: with owner 1, assert p_switch_req[3] with target 0 and p_fatal[2] -> no state change, proc_enable stays 4'b0010.
- Fatal priority: owner 1 asserts p_fatal[1] and p_switch_req[1] in the same cycle -> ERROR, error=1, error_id=1, error_cause=1; persists after all inputs drop, cleared only by reset.
- Bad target (NUM_PROC=3, ID_W=2): owner 0 requests target 3 -> error_cause=2, error_id=0.
- Watchdog (SCHED_WATCHDOG_EN, WDT_CYCLES=8): hold p_mem_enable[owner]=0 -> error_cause=3 after 8 RUN cycles; toggling mem_enable every 5 cycles never trips it.
